// File: rtl/freq_pkg.sv
// ============================================================================
// freq_pkg : shared widths, depth and scan-state encoding for freq_voice_ram
// Revision : 1.0
// ============================================================================
`default_nettype none

package freq_pkg;

    localparam int FREQ_WIDTH  = 20;
    localparam int VOICE_DEPTH = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/freq_scan_ctrl.sv
// ============================================================================
// freq_scan_ctrl : per-tick scan FSM, index counter, beat snapshot, overrun
// Revision : 1.0
// ============================================================================
`default_nettype none

module freq_scan_ctrl
    import freq_pkg::*;
#(
    parameter int WIDTH = FREQ_WIDTH,
    parameter int DEPTH = VOICE_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             scan_ready,
    output logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_active,
    output logic             scan_valid,
    output logic [AW-1:0]    scan_addr,
    output logic [WIDTH-1:0] scan_data,
    output logic             scan_active,
    output logic             scan_last,
    output logic             busy,
    output logic             overrun
);

    scan_state_t   state;
    logic [AW-1:0] next_addr;

    assign next_addr = AW'(scan_addr + 1'b1);
    // Storage is looked up at the index about to be loaded, so each beat is a snapshot.
    assign load_addr = (state == ST_SEND) ? next_addr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            scan_valid  <= 1'b0;
            scan_addr   <= '0;
            scan_data   <= '0;
            scan_active <= 1'b0;
            scan_last   <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state       <= ST_SEND;
                        busy        <= 1'b1;
                        scan_valid  <= 1'b1;
                        scan_addr   <= '0;
                        scan_data   <= load_data;
                        scan_active <= load_active;
                        scan_last   <= 1'b0;
                    end
                end
                ST_SEND: begin
                    overrun <= tick;
                    if (scan_ready) begin
                        if (scan_last) begin
                            state       <= ST_IDLE;
                            busy        <= 1'b0;
                            scan_valid  <= 1'b0;
                            scan_last   <= 1'b0;
                            scan_addr   <= '0;
                            scan_data   <= '0;
                            scan_active <= 1'b0;
                        end else begin
                            scan_addr   <= next_addr;
                            scan_data   <= load_data;
                            scan_active <= load_active;
                            scan_last   <= (next_addr == AW'(DEPTH - 1));
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/freq_voice_ram.sv
// ============================================================================
// freq_voice_ram : per-voice tuning-word store with active flags and scan port
// Revision : 1.0
// ============================================================================
`default_nettype none

module freq_voice_ram
    import freq_pkg::*;
#(
    parameter  int WIDTH = FREQ_WIDTH,
    parameter  int DEPTH = VOICE_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             off_en,
    input  logic [AW-1:0]    off_addr,
    input  logic             clr_all,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_active,
    input  logic             tick,
    output logic             scan_valid,
    input  logic             scan_ready,
    output logic [AW-1:0]    scan_addr,
    output logic [WIDTH-1:0] scan_data,
    output logic             scan_active,
    output logic             scan_last,
    output logic             busy,
    output logic             overrun
);

    logic [WIDTH-1:0] words [DEPTH];
    logic [DEPTH-1:0] flags;
    logic [AW-1:0]    load_addr;
    logic [WIDTH-1:0] load_data;
    logic             load_active;

    // Out-of-range indices match no entry: writes drop, reads return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) words[i] <= '0;
            flags <= '0;
        end else if (clr_all) begin
            for (int i = 0; i < DEPTH; i++) words[i] <= '0;
            flags <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && (wr_addr == AW'(i))) begin
                    words[i] <= wr_data;
                    flags[i] <= 1'b1;
                end
                if (off_en && (off_addr == AW'(i))) flags[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data     = '0;
        rd_active   = 1'b0;
        load_data   = '0;
        load_active = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_data   = words[i];
                rd_active = flags[i];
            end
            if (load_addr == AW'(i)) begin
                load_data   = words[i];
                load_active = flags[i];
            end
        end
    end

    freq_scan_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_scan (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .scan_ready  (scan_ready),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_active (load_active),
        .scan_valid  (scan_valid),
        .scan_addr   (scan_addr),
        .scan_data   (scan_data),
        .scan_active (scan_active),
        .scan_last   (scan_last),
        .busy        (busy),
        .overrun     (overrun)
    );

endmodule

`default_nettype wire

// File: tb/tb_freq_voice_ram.sv
// ============================================================================
// tb_freq_voice_ram : directed + randomized bench against a behavioural model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_freq_voice_ram;

    logic        clk, rst_n;
    logic        wr_en, off_en, clr_all, tick, scan_ready;
    logic [2:0]  wr_addr, off_addr, rd_addr;
    logic [19:0] wr_data;
    logic [19:0] rd_data, scan_data;
    logic        rd_active, scan_valid, scan_active, scan_last, busy, overrun;
    logic [2:0]  scan_addr;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: storage arrays plus the beat currently presented.
    logic [19:0] mw [8];
    logic        mf [8];
    bit          m_busy, m_ovr;
    int          m_idx;
    logic [19:0] m_word;
    logic        m_act;
    int          hs_count, ovr_count, start_count;

    freq_voice_ram dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .off_en(off_en), .off_addr(off_addr), .clr_all(clr_all),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_active(rd_active),
        .tick(tick), .scan_valid(scan_valid), .scan_ready(scan_ready),
        .scan_addr(scan_addr), .scan_data(scan_data), .scan_active(scan_active),
        .scan_last(scan_last), .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin mw[i] = '0; mf[i] = 1'b0; end
        m_busy = 0; m_ovr = 0; m_idx = 0; m_word = '0; m_act = 1'b0;
    endtask

    // Applies the rules of one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit pre_busy;
        if (!rst_n) begin model_reset(); return; end
        pre_busy = m_busy;
        m_ovr    = pre_busy && tick;
        if (!pre_busy) begin
            if (tick) begin
                m_busy = 1; m_idx = 0; m_word = mw[0]; m_act = mf[0];
            end
        end else if (scan_ready) begin
            if (m_idx == 7) m_busy = 0;
            else begin m_idx++; m_word = mw[m_idx]; m_act = mf[m_idx]; end
        end
        if (clr_all) begin
            for (int i = 0; i < 8; i++) begin mw[i] = '0; mf[i] = 1'b0; end
        end else begin
            if (wr_en)  begin mw[wr_addr] = wr_data; mf[wr_addr] = 1'b1; end
            if (off_en) mf[off_addr] = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("rd_data",    32'(rd_data),    32'(mw[rd_addr]));
        chk("rd_active",  32'(rd_active),  32'(mf[rd_addr]));
        chk("busy",       32'(busy),       32'(m_busy));
        chk("scan_valid", 32'(scan_valid), 32'(m_busy));
        chk("overrun",    32'(overrun),    32'(m_ovr));
        chk("scan_last",  32'(scan_last),  32'(m_busy && m_idx == 7));
        if (m_busy) begin
            chk("scan_addr",   32'(scan_addr),   32'(m_idx));
            chk("scan_data",   32'(scan_data),   32'(m_word));
            chk("scan_active", 32'(scan_active), 32'(m_act));
        end
    endtask

    task automatic cyc();
        bit hs, was_busy;
        hs       = scan_valid && scan_ready;
        was_busy = busy;
        @(posedge clk);
        model_edge();
        #1;
        if (hs) hs_count++;
        if (overrun) ovr_count++;
        if (busy && !was_busy) start_count++;
        check_all();
    endtask

    task automatic clear_inputs();
        wr_en = 0; off_en = 0; clr_all = 0; tick = 0;
    endtask

    task automatic write(input logic [2:0] a, input logic [19:0] d);
        wr_en = 1; wr_addr = a; wr_data = d; cyc(); wr_en = 0;
    endtask

    task automatic pulse_tick();
        tick = 1; cyc(); tick = 0;
    endtask

    task automatic wait_beat(input int idx);
        for (int n = 0; n < 40 && !(scan_valid && scan_addr == 3'(idx)); n++) cyc();
        chk("wait_beat", 32'(scan_valid && scan_addr == 3'(idx)), 32'd1);
    endtask

    task automatic run_to_idle();
        for (int n = 0; n < 60 && busy; n++) cyc();
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic clear_counts();
        hs_count = 0; ovr_count = 0; start_count = 0;
    endtask

    initial begin
        rst_n = 0; clear_inputs(); scan_ready = 0;
        wr_addr = 0; off_addr = 0; rd_addr = 0; wr_data = 0;
        model_reset(); clear_counts();
        #12;
        chk("rst_scan_valid", 32'(scan_valid), 32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_overrun",    32'(overrun),    32'd0);
        chk("rst_scan_last",  32'(scan_last),  32'd0);
        chk("rst_scan_addr",  32'(scan_addr),  32'd0);
        chk("rst_scan_data",  32'(scan_data),  32'd0);
        chk("rst_rd_data",    32'(rd_data),    32'd0);
        #1 rst_n = 1;

        // 1: basic writes and random reads
        write(3'd3, 20'h12345);
        write(3'd7, 20'h0ABCD);
        rd_addr = 3; #1;
        chk("t1_rd3",     32'(rd_data),   32'h12345);
        chk("t1_act3",    32'(rd_active), 32'd1);
        rd_addr = 7; #1;
        chk("t1_rd7",     32'(rd_data),   32'h0ABCD);
        chk("t1_act7",    32'(rd_active), 32'd1);

        // 2: full scan with no back-pressure
        scan_ready = 1; clear_counts();
        pulse_tick();
        run_to_idle();
        chk("t2_beats",  32'(hs_count),    32'd8);
        chk("t2_starts", 32'(start_count), 32'd1);

        // 3: stall on beat 3 while overwriting its entry
        pulse_tick();
        wait_beat(3);
        scan_ready = 0;
        write(3'd3, 20'hFFFFF);
        for (int i = 0; i < 4; i++) cyc();
        chk("t3_stalled_data", 32'(scan_data), 32'h12345);
        chk("t3_stalled_addr", 32'(scan_addr), 32'd3);
        scan_ready = 1;
        run_to_idle();
        pulse_tick();
        wait_beat(3);
        chk("t3_new_data", 32'(scan_data), 32'hFFFFF);
        run_to_idle();

        // 4: tick during beat 5 raises overrun once and does not restart
        clear_counts();
        pulse_tick();
        wait_beat(5);
        pulse_tick();
        run_to_idle();
        for (int i = 0; i < 4; i++) cyc();
        chk("t4_overruns", 32'(ovr_count),   32'd1);
        chk("t4_beats",    32'(hs_count),    32'd8);
        chk("t4_starts",   32'(start_count), 32'd1);

        // 5: same-edge priority
        wr_en = 1; off_en = 1; wr_addr = 2; off_addr = 2; wr_data = 20'h00077; rd_addr = 2;
        cyc(); clear_inputs();
        chk("t5_word2", 32'(rd_data),   32'h00077);
        chk("t5_flag2", 32'(rd_active), 32'd0);
        clr_all = 1; wr_en = 1; wr_addr = 4; wr_data = 20'h54321; rd_addr = 4;
        cyc(); clear_inputs();
        chk("t5_word4", 32'(rd_data), 32'd0);
        write(3'd1, 20'h00111);
        write(3'd6, 20'h00666);

        // 6: asynchronous reset mid-scan
        pulse_tick();
        wait_beat(4);
        #2 rst_n = 0;
        #1;
        chk("t6_valid_async", 32'(scan_valid), 32'd0);
        chk("t6_busy_async",  32'(busy),       32'd0);
        chk("t6_last_async",  32'(scan_last),  32'd0);
        model_reset();
        cyc(); cyc();
        #2 rst_n = 1;
        pulse_tick();
        chk("t6_rescan_addr", 32'(scan_addr), 32'd0);
        chk("t6_rescan_data", 32'(scan_data), 32'd0);
        run_to_idle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            wr_en      = ($urandom_range(0, 99) < 30);
            off_en     = ($urandom_range(0, 99) < 15);
            clr_all    = ($urandom_range(0, 99) < 2);
            tick       = ($urandom_range(0, 99) < 5);
            scan_ready = ($urandom_range(0, 99) < 70);
            wr_addr    = 3'($urandom);
            off_addr   = 3'($urandom);
            rd_addr    = 3'($urandom);
            wr_data    = 20'($urandom);
            cyc();
        end
        clear_inputs(); scan_ready = 1;
        run_to_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
